// File: rtl/unified_mem_arb.sv
// ---------------------------------------------------------------------------
// unified_mem_arb
//   Shares one single-port RAM between the instruction-fetch requester and
//   the data requester. Each access holds mem_ce for WAIT_CYCLES cycles.
//   The read data is registered and an ack pulses for one cycle when the
//   access completes. stall stays high while any request is unserved.
//
//   Optional feature macro: UNIFIED_MEM_ARB_FAIR_EN
//     undefined : strict data-over-fetch priority.
//     defined   : when both requests are eligible at the same edge, the
//                 requester not served last wins (last_grant flop, reset = data).
//
// Parameters
//   WAIT_CYCLES  memory access cycles with mem_ce high (legal 1..15)
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports
//   clk, rst                    rising-edge clock, async active-low reset
//   if_req/if_addr              fetch request (level, held until if_ack)
//   if_rdata/if_ack             registered fetch data, 1-cycle completion
//   d_req/d_we/d_addr/d_wdata   data request (level, held until d_ack)
//   d_rdata/d_ack               registered load data, 1-cycle completion
//   mem_ce/mem_we/mem_addr/
//   mem_wdata/mem_rdata         single-port RAM interface
//   stall                       any request still waiting for its ack
// ---------------------------------------------------------------------------
module unified_mem_arb #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_if_elig;
  logic                w_d_elig;
  logic                w_pick_d;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_done;

  // A requester whose ack is visible this cycle is dropping its request;
  // it must not be granted again at this edge.
  assign w_if_elig = if_req & ~r_if_ack;
  assign w_d_elig  = d_req  & ~r_d_ack;

`ifdef UNIFIED_MEM_ARB_FAIR_EN
  // 0 = data served last, 1 = fetch served last.
  logic r_last_grant;

  assign w_pick_d = w_d_elig & (~w_if_elig | r_last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_i) begin
      r_last_grant <= 1'b1;
    end
  end
`else
  assign w_pick_d = w_d_elig;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant/complete strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d   = 1'b1;
          w_state_nxt = BUSY_D;
        end else if (w_if_elig) begin
          w_grant_i   = 1'b1;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Access datapath: request fields are captured only at grant and held
  // stable for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant_d) begin
        r_mem_addr  <= d_addr;
        r_mem_we    <= d_we;
        r_mem_wdata <= d_wdata;
        r_cnt       <= CNT_INIT;
      end else if (w_grant_i) begin
        r_mem_addr  <= if_addr;
        r_mem_we    <= 1'b0;
        r_mem_wdata <= '0;
        r_cnt       <= CNT_INIT;
      end else if (w_done) begin
        r_mem_we <= 1'b0;
        if (r_state == BUSY_I) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= mem_rdata;
        end else begin
          r_d_ack <= 1'b1;
          if (!r_mem_we) begin
            r_d_rdata <= mem_rdata;
          end
        end
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign mem_ce    = (r_state != IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign stall     = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule
